// File: rtl/word_byte_serializer_pkg.sv
// Shared widths and FSM state encoding for the 16-to-8 bit word serializer.
package word_byte_serializer_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned STATE_W = 2;

  // Encoding 2'd3 is unused and recovers to IDLE.
  localparam logic [STATE_W-1:0] ST_IDLE        = 2'd0;
  localparam logic [STATE_W-1:0] ST_SEND_FIRST  = 2'd1;
  localparam logic [STATE_W-1:0] ST_SEND_SECOND = 2'd2;

endpackage

// File: rtl/word_byte_serializer_byte_select.sv
// Picks the byte of the held word that goes out in the current phase.
module word_byte_serializer_byte_select
  import word_byte_serializer_pkg::*;
#(
  parameter logic HI_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_second,
  output logic [BYTE_W-1:0] o_byte
);

  logic w_take_hi;

  // High half goes first when HI_FIRST, so the phase flips the choice.
  assign w_take_hi = HI_FIRST ^ i_second;
  assign o_byte    = w_take_hi ? i_word[WORD_W-1 -: BYTE_W] : i_word[BYTE_W-1:0];

endmodule

// File: rtl/word_byte_serializer.sv
// Splits 16-bit words into two 8-bit bytes with valid/ready on both sides,
// sustaining one byte per cycle including back-to-back words.
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter logic HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [WORD_W-1:0]  r_word;
  logic               r_last;
  logic               w_in_accept;
  logic               w_sending;
  logic               w_second;
  logic [BYTE_W-1:0]  w_byte;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Word holding register; cleared on reset so a cut-off word never resurfaces.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
      r_last <= 1'b0;
    end else if (w_in_accept) begin
      r_word <= in_data;
      r_last <= in_last;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SEND_FIRST;
      end
      ST_SEND_FIRST: begin
        if (out_ready) w_state_nxt = ST_SEND_SECOND;
      end
      ST_SEND_SECOND: begin
        // Next word may be taken as the last byte leaves: no bubble.
        in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ST_SEND_FIRST : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_accept = in_valid & in_ready;
  assign w_second    = (r_state == ST_SEND_SECOND);
  assign w_sending   = (r_state == ST_SEND_FIRST) | w_second;

  word_byte_serializer_byte_select #(
    .HI_FIRST (HI_FIRST)
  ) u_byte_select (
    .i_word   (r_word),
    .i_second (w_second),
    .o_byte   (w_byte)
  );

  assign out_valid = w_sending;
  assign out_data  = w_sending ? w_byte : '0;
  assign out_last  = w_second & r_last;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-queue model.
module tb_word_byte_serializer;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } byte_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        out_ready;

  logic        hi_in_ready, hi_out_last, hi_out_valid;
  logic [7:0]  hi_out_data;
  logic        lo_in_ready, lo_out_last, lo_out_valid;
  logic [7:0]  lo_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.HI_FIRST(1'b1)) dut_hi (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(hi_in_ready), .out_data(hi_out_data),
    .out_last(hi_out_last), .out_valid(hi_out_valid), .out_ready(out_ready)
  );

  word_byte_serializer #(.HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(lo_in_ready), .out_data(lo_out_data),
    .out_last(lo_out_last), .out_valid(lo_out_valid), .out_ready(out_ready)
  );

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'hFFFF; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", hi_out_valid); end
    n_checks++; if (hi_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", hi_out_data); end
    n_checks++; if (hi_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", hi_out_last); end
    n_checks++; if (hi_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", hi_in_ready); end
    n_checks++; if (lo_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lo_out_valid got %b exp 0", lo_out_valid); end
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; in_data = 16'hA55A; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_data = 16'h0000; #1;
    n_checks++; if (hi_out_valid !== 1'b1 || hi_out_data !== 8'hA5 || hi_out_last !== 1'b0)
      begin n_fail++; $display("FAIL single_first got v=%b d=%h l=%b exp v=1 d=a5 l=0", hi_out_valid, hi_out_data, hi_out_last); end
    n_checks++; if (hi_in_ready !== 1'b0) begin n_fail++; $display("FAIL single_first_in_ready got %b exp 0", hi_in_ready); end
    @(posedge clk); #2;
    n_checks++; if (hi_out_valid !== 1'b1 || hi_out_data !== 8'h5A || hi_out_last !== 1'b1)
      begin n_fail++; $display("FAIL single_second got v=%b d=%h l=%b exp v=1 d=5a l=1", hi_out_valid, hi_out_data, hi_out_last); end
    n_checks++; if (hi_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_second_in_ready got %b exp 1", hi_in_ready); end
    @(posedge clk); #2;
    n_checks++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid got %b exp 0", hi_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    logic       exp_r [4];
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
    exp_r[0] = 1'b0;  exp_r[1] = 1'b1;  exp_r[2] = 1'b0;  exp_r[3] = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 in_data = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) in_valid = 1'b0;
      #1;
      n_checks++; if (hi_out_valid !== 1'b1 || hi_out_data !== exp_b[i] || hi_out_last !== 1'b0)
        begin n_fail++; $display("FAIL b2b_byte%0d got v=%b d=%h l=%b exp v=1 d=%h l=0", i, hi_out_valid, hi_out_data, hi_out_last, exp_b[i]); end
      n_checks++; if (hi_in_ready !== exp_r[i])
        begin n_fail++; $display("FAIL b2b_in_ready%0d got %b exp %b", i, hi_in_ready, exp_r[i]); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; #1;
    n_checks++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %b exp 0", hi_out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 16'hA55A; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (hi_out_valid !== 1'b1 || hi_out_data !== 8'hA5 || hi_in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp v=1 d=a5 rdy=0", i, hi_out_valid, hi_out_data, hi_in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_checks++; if (hi_out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_release got %h exp a5", hi_out_data); end
    @(posedge clk); #2;
    n_checks++; if (hi_out_valid !== 1'b1 || hi_out_data !== 8'h5A || hi_out_last !== 1'b0)
      begin n_fail++; $display("FAIL bp_second got v=%b d=%h l=%b exp v=1 d=5a l=0", hi_out_valid, hi_out_data, hi_out_last); end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1; in_data = 16'hC3D4; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (hi_out_data !== 8'hD4) begin n_fail++; $display("FAIL rmw_pre got %h exp d4", hi_out_data); end
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0; #1;
    n_checks++; if (hi_out_valid !== 1'b0 || hi_out_data !== 8'h00)
      begin n_fail++; $display("FAIL rmw_after got v=%b d=%h exp v=0 d=00", hi_out_valid, hi_out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_checks++; if (hi_out_valid !== 1'b0 || hi_out_data === 8'hD4)
        begin n_fail++; $display("FAIL rmw_discard%0d got v=%b d=%h exp v=0 and not d4", i, hi_out_valid, hi_out_data); end
    end
  endtask

  task automatic test_hi_first0();
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; #1;
    n_checks++; if (lo_out_valid !== 1'b1 || lo_out_data !== 8'hEF || lo_out_last !== 1'b0)
      begin n_fail++; $display("FAIL lo_first got v=%b d=%h l=%b exp v=1 d=ef l=0", lo_out_valid, lo_out_data, lo_out_last); end
    @(posedge clk); #2;
    n_checks++; if (lo_out_valid !== 1'b1 || lo_out_data !== 8'hBE || lo_out_last !== 1'b1)
      begin n_fail++; $display("FAIL lo_second got v=%b d=%h l=%b exp v=1 d=be l=1", lo_out_valid, lo_out_data, lo_out_last); end
    @(posedge clk); #2;
    n_checks++; if (lo_out_valid !== 1'b0) begin n_fail++; $display("FAIL lo_idle got %b exp 0", lo_out_valid); end
  endtask

  // Model: FIFO of bytes still owed per byte order; pending count decides in_ready.
  task automatic test_random();
    byte_t q_hi[$];
    byte_t q_lo[$];
    int    pending;
    logic  exp_ir;
    int    errs;
    errs = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(63) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 16'($urandom);
      in_last   = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      pending = q_hi.size();
      exp_ir  = (pending == 0) || (pending == 1 && out_ready);
      n_checks++;
      if (hi_in_ready !== exp_ir || lo_in_ready !== exp_ir || hi_out_valid !== (pending > 0) || lo_out_valid !== (pending > 0)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ctrl cyc%0d got rdy=%b/%b v=%b/%b exp rdy=%b v=%b", i,
                                hi_in_ready, lo_in_ready, hi_out_valid, lo_out_valid, exp_ir, pending > 0);
      end
      if (pending > 0) begin
        n_checks++;
        if (hi_out_data !== q_hi[0].d || hi_out_last !== q_hi[0].l || lo_out_data !== q_lo[0].d || lo_out_last !== q_lo[0].l) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_data cyc%0d got %h/%b %h/%b exp %h/%b %h/%b", i,
                                  hi_out_data, hi_out_last, lo_out_data, lo_out_last,
                                  q_hi[0].d, q_hi[0].l, q_lo[0].d, q_lo[0].l);
        end
      end
      if (reset) begin
        q_hi.delete(); q_lo.delete();
      end else begin
        if (pending > 0 && out_ready) begin
          void'(q_hi.pop_front()); void'(q_lo.pop_front());
        end
        if (in_valid && exp_ir) begin
          q_hi.push_back('{d: in_data[15:8], l: 1'b0});
          q_hi.push_back('{d: in_data[7:0],  l: in_last});
          q_lo.push_back('{d: in_data[7:0],  l: 1'b0});
          q_lo.push_back('{d: in_data[15:8], l: in_last});
        end
      end
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_hi_first0();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
